// File: rtl/ls299_if.sv
// Bus-side signal bundle for the ls299 shift/storage register: chip-clock enable,
// mode and serial inputs, output enables, and the shared parallel I/O pins.
interface ls299_if;
  logic       cen;
  logic       s0;
  logic       s1;
  logic       ds0;
  logic       ds7;
  logic       oe1_n;
  logic       oe2_n;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       io_oe;
  logic       q0;
  logic       q7;

  modport master (
    output cen, s0, s1, ds0, ds7, oe1_n, oe2_n, io_in,
    input  io_out, io_oe, q0, q7
  );

  modport slave (
    input  cen, s0, s1, ds0, ds7, oe1_n, oe2_n, io_in,
    output io_out, io_oe, q0, q7
  );
endinterface

// File: rtl/ls299.sv
// 74LS299 8-bit universal shift/storage register. The chip CP edge is modelled
// as the cen enable on clk; MR maps onto the asynchronous reset_n.
module ls299 (
  input logic   clk,
  input logic   reset_n,
  ls299_if.slave bus
);

  logic [7:0] r;

  // Next register value for a given mode; hold covers mode 00.
  function automatic logic [7:0] next_r(
    input logic [1:0] mode,
    input logic [7:0] cur,
    input logic       ser_r,
    input logic       ser_l,
    input logic [7:0] par
  );
    logic [7:0] nxt;
    nxt = cur;
    case (mode)
      2'b01:   nxt = {cur[6:0], ser_r};
      2'b10:   nxt = {ser_l, cur[7:1]};
      2'b11:   nxt = par;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Register stage: updates only on chip-clock edges, cleared at once by MR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r <= 8'h00;
    end else if (bus.cen) begin
      r <= next_r({bus.s1, bus.s0}, r, bus.ds0, bus.ds7, bus.io_in);
    end
  end

  assign bus.io_out = r;
  assign bus.q0     = r[0];
  assign bus.q7     = r[7];
  // Drivers drop out in load mode so a load never samples our own outputs.
  assign bus.io_oe  = ~bus.oe1_n & ~bus.oe2_n & ~(bus.s1 & bus.s0);

endmodule

// File: doc/ls299.md
# ls299

Cycle-accurate synchronous model of the 74LS299 8-bit universal shift/storage register with shared parallel I/O pins. It is the serial/parallel conversion counterpart to the combinational TTL gate models in the logic library. The board-level netlist uses it to load bytes from a bus and shift them out serially, or to assemble serial bits and drive them back onto the bus. The chip clock is modelled as a clock enable on the single system clock. The chip's master-reset pin maps onto the block reset.

## Interface
Parameters: none; width is fixed at 8 as on the physical part.

Ports (clock and reset first):
- clk  in  1  system clock; the only clock in the block.
- reset_n  in  1  asynchronous, active-low reset (models the MR pin).
- cen  in  1  one-cycle pulse marking a rising edge of the chip CP pin; all register updates occur only on clk edges where cen=1.
- s0  in  1  mode select, bit 0.
- s1  in  1  mode select, bit 1.
- ds0  in  1  serial input shifted into Q0 during shift-right.
- ds7  in  1  serial input shifted into Q7 during shift-left.
- oe1_n  in  1  output enable 1, active low.
- oe2_n  in  1  output enable 2, active low.
- io_in  in  8  value present on I/O0..I/O7 pins (bus side), used for parallel load.
- io_out  out  8  register contents driven toward the I/O pins.
- io_oe  out  1  high when the block drives the I/O pins; the parent applies tri-state or bus muxing.
- q0  out  1  always-enabled serial output of stage 0.
- q7  out  1  always-enabled serial output of stage 7.

## Operation
- Internal register r[7:0]: io_out=r, q0=r[0], q7=r[7].
- Mode {s1,s0} is sampled on each clk edge with cen=1:
  - 00 hold: r unchanged.
  - 01 shift right (toward Q7): r[0]<=ds0; r[n]<=r[n-1] for n=1..7.
  - 10 shift left (toward Q0): r[7]<=ds7; r[n]<=r[n+1] for n=0..6.
  - 11 parallel load: r<=io_in.
- cen=0: r holds regardless of mode or serial inputs.
- io_oe = !oe1_n & !oe2_n & !(s1 & s0). The combinational term disables the drivers during load mode, so the loaded value never comes from the block's own outputs.
- io_out is valid regardless of io_oe. The parent must gate io_out with io_oe.
- Cascading: q7 of one instance feeds ds0 of the next for right shift; q0 of the upper instance feeds ds7 of the lower for left shift.

## Timing
- Reset: when reset_n goes low, r becomes 0 immediately, without waiting for a clock edge. While reset_n is low, io_out=8'h00, q0=0, q7=0, and all cen pulses are ignored.
- Reset release: the first cen pulse after reset_n goes high is acted on normally. There is no extra settle cycle.
- Reset asserted in the same cycle as a load or shift: reset wins and r=0.
- Latency: one clk cycle. A load or shift on the edge with cen=1 is visible on io_out, q0 and q7 after that edge.
- Serial inputs and io_in are sampled only on that edge. Changes between cen pulses have no effect.
- io_oe is purely combinational from s0, s1, oe1_n and oe2_n, with zero latency. It does not depend on reset.
- Boundary behaviour at the register ends:
  - Shift right: the old r[7] is discarded.
  - Shift left: the old r[0] is discarded.
  - There is no wrap-around unless the parent wires q7 to ds0 (or q0 to ds7) externally.
- Mode change between pulses: the mode present at the cen edge is the only one applied. There is no glitch or partial update.

## Test plan
- Reset: reset_n=0 asynchronously, mid-cycle, after loading 8'hA5 -> io_out=00, q0=0 and q7=0 within the same cycle, before any clk edge. cen pulses with s=11 and io_in=FF while reset_n=0 -> io_out stays 00.
- Load/hold: s=11, io_in=8'h3C, one cen -> io_out=3C. Then s=00 with 5 cen pulses and cen=0 cycles with s=01 -> io_out remains 3C.
- Shift right: load 8'h81, s=01, ds0=0, four cen pulses -> io_out=10, q7 sequence 1,0,0,0,0 (sampled after each pulse, starting from the load). Then ds0=1 for one pulse -> io_out=21.
- Shift left: load 8'h81, s=10, ds7=1, three cen pulses -> io_out sequence C0, E0, F0; q0=0 after the first pulse.
- Output enable: load 8'h5A and apply each oe1_n/oe2_n combination -> io_oe=1 only for 0/0. With oe=0/0, switching to s=11 -> io_oe=0 in the same cycle; io_out still 5A until the next cen.
- Cascade: two instances with q7 of the first tied to ds0 of the second; load 12 and 34, s=01 with ds0=0 on the first, eight cen pulses -> first=00, second=12.
